// File: rtl/frame_read_scheduler_pkg.sv
// Shared types and default frame-buffer base addresses for the frame read scheduler.
package frame_read_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef logic [1:0] buf_idx_t;

  localparam logic [31:0] DEF_BASE_ADDR0 = 32'h1000_0000;
  localparam logic [31:0] DEF_BASE_ADDR1 = 32'h1004_0000;
  localparam logic [31:0] DEF_BASE_ADDR2 = 32'h1008_0000;

  function automatic logic [31:0] base_of(input buf_idx_t idx, input logic [31:0] b0,
                                          input logic [31:0] b1, input logic [31:0] b2);
    case (idx)
      2'd0:    return b0;
      2'd1:    return b1;
      default: return b2;
    endcase
  endfunction

endpackage

// File: rtl/frame_read_scheduler_arbiter.sv
// Triple-buffer role tracker: write/pending/read buffer indices, drop counter, writer base.
// wr_base_addr lags a W change by one cycle; rd_base_addr follows R combinationally.
module frame_buffer_arbiter
  import frame_read_scheduler_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR0 = DEF_BASE_ADDR0,
  parameter logic [31:0] BASE_ADDR1 = DEF_BASE_ADDR1,
  parameter logic [31:0] BASE_ADDR2 = DEF_BASE_ADDR2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_frame_done,
  input  logic        vsync_start_pulse,
  output logic [15:0] frame_drop_cnt,
  output logic [31:0] wr_base_addr,
  output logic [31:0] rd_base_addr
);

  buf_idx_t w_idx, p_idx, r_idx;
  logic     pending_valid;

  buf_idx_t w_nxt, p_mid, p_nxt, r_nxt;
  logic     pv_mid, pv_nxt;

  // Writer swap is resolved first so a same-cycle vsync picks up the frame just finished.
  always_comb begin
    w_nxt  = w_idx;
    p_mid  = p_idx;
    pv_mid = pending_valid;
    if (wr_frame_done) begin
      w_nxt  = p_idx;
      p_mid  = w_idx;
      pv_mid = 1'b1;
    end
    r_nxt  = r_idx;
    p_nxt  = p_mid;
    pv_nxt = pv_mid;
    if (vsync_start_pulse && pv_mid) begin
      r_nxt  = p_mid;
      p_nxt  = r_idx;
      pv_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_idx          <= 2'd0;
      p_idx          <= 2'd1;
      r_idx          <= 2'd2;
      pending_valid  <= 1'b0;
      frame_drop_cnt <= 16'd0;
      wr_base_addr   <= BASE_ADDR0;
    end else begin
      w_idx         <= w_nxt;
      p_idx         <= p_nxt;
      r_idx         <= r_nxt;
      pending_valid <= pv_nxt;
      if (wr_frame_done && pending_valid && frame_drop_cnt != 16'hFFFF)
        frame_drop_cnt <= frame_drop_cnt + 16'd1;
      wr_base_addr <= base_of(w_idx, BASE_ADDR0, BASE_ADDR1, BASE_ADDR2);
    end
  end

  assign rd_base_addr = base_of(r_idx, BASE_ADDR0, BASE_ADDR1, BASE_ADDR2);

endmodule

// File: rtl/frame_read_scheduler.sv
// Schedules DDR read bursts of the display buffer into the line FIFO, one registered request at a time.
// Requests are held until accepted; issue is throttled by outstanding count and FIFO free space.
module frame_read_scheduler
  import frame_read_scheduler_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR0   = DEF_BASE_ADDR0,
  parameter logic [31:0] BASE_ADDR1   = DEF_BASE_ADDR1,
  parameter logic [31:0] BASE_ADDR2   = DEF_BASE_ADDR2,
  parameter int          BURST_WORDS  = 16,
  parameter int          BURST_BYTES  = 128,
  parameter int          FRAME_BURSTS = 1200,
  parameter int          MAX_OUT      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        vsync_start_pulse,
  input  logic        wr_frame_done,
  output logic [31:0] wr_base_addr,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_burst_done,
  input  logic [9:0]  fifo_free,
  output logic [15:0] frame_drop_cnt,
  output logic        late_frame
);

  localparam int IDX_W = $clog2(FRAME_BURSTS + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_t             state;
  logic [IDX_W-1:0]   burst_idx;
  logic [OUT_W-1:0]   outstanding;
  logic [31:0]        rd_base_addr;
  logic [31:0]        rd_next_addr;
  logic [10:0]        fifo_need;
  logic               handshake, done_ok, idx_left, out_room, fifo_room, issue, idle_bus;

  frame_buffer_arbiter #(
    .BASE_ADDR0(BASE_ADDR0),
    .BASE_ADDR1(BASE_ADDR1),
    .BASE_ADDR2(BASE_ADDR2)
  ) u_arb (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_frame_done    (wr_frame_done),
    .vsync_start_pulse(vsync_start_pulse),
    .frame_drop_cnt   (frame_drop_cnt),
    .wr_base_addr     (wr_base_addr),
    .rd_base_addr     (rd_base_addr)
  );

  assign handshake    = rd_req && rd_ack;
  assign done_ok      = rd_burst_done && (outstanding != '0);
  assign idx_left     = burst_idx < IDX_W'(FRAME_BURSTS);
  assign out_room     = outstanding < OUT_W'(MAX_OUT);
  // Space is reserved for every burst already in flight plus the one about to be issued.
  assign fifo_need    = 11'((int'(outstanding) + 1) * BURST_WORDS);
  assign fifo_room    = {1'b0, fifo_free} >= fifo_need;
  assign issue        = (state == ST_RUN) && enable && !vsync_start_pulse && !rd_req &&
                        idx_left && out_room && fifo_room;
  assign idle_bus     = (outstanding == '0) && !rd_req;
  assign rd_next_addr = rd_base_addr + 32'(burst_idx) * 32'(BURST_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      burst_idx   <= '0;
      outstanding <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= 32'd0;
      late_frame  <= 1'b0;
    end else begin
      if (issue) begin
        rd_req  <= 1'b1;
        rd_addr <= rd_next_addr;
      end else if (handshake) begin
        rd_req <= 1'b0;
      end

      case ({handshake, done_ok})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: ;
      endcase

      if (handshake)
        burst_idx <= burst_idx + IDX_W'(1);

      if (!enable) begin
        if (state == ST_DRAIN) begin
          if (idle_bus) state <= ST_IDLE;
        end else if (state != ST_IDLE) begin
          state <= ST_DRAIN;
        end
      end else begin
        case (state)
          ST_IDLE: state <= ST_ARM;
          ST_ARM: begin
            if (vsync_start_pulse) begin
              state     <= ST_RUN;
              burst_idx <= '0;
            end
          end
          ST_RUN: begin
            // A vsync that lands exactly on a fully issued frame simply restarts it.
            if (vsync_start_pulse) begin
              if (idx_left) begin
                late_frame <= 1'b1;
                state      <= ST_DRAIN;
              end else begin
                burst_idx <= '0;
              end
            end else if (!idx_left && !rd_req) begin
              state <= ST_ARM;
            end
          end
          ST_DRAIN: begin
            if (idle_bus) begin
              state     <= ST_RUN;
              burst_idx <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_read_scheduler.sv
// Directed bench for frame_read_scheduler; a small reader model returns burst completions.
module tb_frame_read_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, enable, vsync_start_pulse, wr_frame_done, rd_ack;
  logic        rd_burst_done = 1'b0;
  logic [9:0]  fifo_free;
  logic [31:0] wr_base_addr, rd_addr;
  logic        rd_req, late_frame;
  logic [15:0] frame_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  bit auto_done = 1'b0;
  int done_budget = 0;
  int done_issued = 0;
  int pend = 0;
  int hs_cnt = 0;
  bit prev_hs = 1'b0;

  frame_read_scheduler u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .vsync_start_pulse(vsync_start_pulse),
    .wr_frame_done    (wr_frame_done),
    .wr_base_addr     (wr_base_addr),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_ack           (rd_ack),
    .rd_burst_done    (rd_burst_done),
    .fifo_free        (fifo_free),
    .frame_drop_cnt   (frame_drop_cnt),
    .late_frame       (late_frame)
  );

  always #5 clk = ~clk;

  // Reader model: counts accepted bursts and returns one completion per cycle when allowed.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      pend          = 0;
      prev_hs       = 1'b0;
      hs_cnt        = 0;
      done_issued   = 0;
      rd_burst_done = 1'b0;
    end else begin
      if (prev_hs) pend++;
      if (rd_burst_done) pend--;
      prev_hs = rd_req && rd_ack;
      if (prev_hs) hs_cnt++;
      if (pend > 0 && (auto_done || done_issued < done_budget)) begin
        rd_burst_done = 1'b1;
        done_issued++;
      end else begin
        rd_burst_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_req(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_base"}, wr_base_addr, 32'h1000_0000);
    check({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    check({tag, "_rd_addr"}, rd_addr, 32'd0);
    check({tag, "_drop"}, 32'(frame_drop_cnt), 32'd0);
    check({tag, "_late"}, 32'(late_frame), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; enable = 1'b0; vsync_start_pulse = 1'b0; wr_frame_done = 1'b0;
    rd_ack = 1'b0; fifo_free = 10'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Basic issue with free space and immediate accept
    rst_n = 1'b1; enable = 1'b1; fifo_free = 10'd1023; rd_ack = 1'b1;
    repeat (3) @(negedge clk);
    vsync_start_pulse = 1'b1;
    @(negedge clk);
    vsync_start_pulse = 1'b0;
    wait_req(20, seen);
    check("first_req_seen", 32'(seen), 32'd1);
    check("first_addr", rd_addr, 32'h1008_0000);
    @(negedge clk);
    wait_req(20, seen);
    check("second_req_seen", 32'(seen), 32'd1);
    check("second_addr", rd_addr, 32'h1008_0080);
    repeat (30) @(negedge clk);
    check("max_out_accepted", 32'(hs_cnt), 32'd4);
    check("max_out_no_req", 32'(rd_req), 32'd0);

    // FIFO space throttle: two completions leave 2 outstanding, 40 words is not enough
    fifo_free = 10'd40;
    done_budget = done_issued + 2;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fifo40_no_req", 32'(rd_req), 32'd0);
    end
    fifo_free = 10'd48;
    @(negedge clk);
    check("fifo48_req", 32'(rd_req), 32'd1);
    check("fifo48_addr", rd_addr, 32'h1008_0200);

    // Late vsync mid-frame after 500 bursts
    fifo_free = 10'd1023;
    auto_done = 1'b1;
    for (int i = 0; i < 4000 && hs_cnt < 500; i++) @(negedge clk);
    check("reached_500", 32'(hs_cnt >= 500), 32'd1);
    fifo_free = 10'd0;
    repeat (3) @(negedge clk);
    check("late_before", 32'(late_frame), 32'd0);
    wr_frame_done = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b0;
    vsync_start_pulse = 1'b1; fifo_free = 10'd1023; rd_ack = 1'b0;
    @(negedge clk);
    vsync_start_pulse = 1'b0;
    check("late_set", 32'(late_frame), 32'd1);
    wait_req(50, seen);
    check("restart_req_seen", 32'(seen), 32'd1);
    check("restart_addr", rd_addr, 32'h1000_0000);
    check("restart_wr_base", wr_base_addr, 32'h1004_0000);

    // Held request stays stable while not accepted
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_req", 32'(rd_req), 32'd1);
      check("held_addr", rd_addr, 32'h1000_0000);
    end
    check("late_sticky", 32'(late_frame), 32'd1);

    // Asynchronous reset mid-frame, applied away from any clock edge
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0; auto_done = 1'b0; done_budget = 0; fifo_free = 10'd0;

    // Two written frames with no display: one drop, writer base lags W by a cycle
    @(negedge clk);
    wr_frame_done = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b0;
    check("wfd1_lag", wr_base_addr, 32'h1000_0000);
    @(negedge clk);
    check("wfd1_base", wr_base_addr, 32'h1004_0000);
    check("wfd1_drop", 32'(frame_drop_cnt), 32'd0);
    wr_frame_done = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b0;
    check("wfd2_base", wr_base_addr, 32'h1004_0000);
    check("wfd2_drop", 32'(frame_drop_cnt), 32'd1);
    @(negedge clk);
    check("wfd2_base_settled", wr_base_addr, 32'h1000_0000);

    // Simultaneous write-done and vsync right after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1; fifo_free = 10'd1023; rd_ack = 1'b1; auto_done = 1'b1;
    repeat (2) @(negedge clk);
    wr_frame_done = 1'b1; vsync_start_pulse = 1'b1;
    @(negedge clk);
    wr_frame_done = 1'b0; vsync_start_pulse = 1'b0;
    check("both_pending", 32'(u_dut.u_arb.pending_valid), 32'd0);
    check("both_r_idx", 32'(u_dut.u_arb.r_idx), 32'd0);
    check("both_drop", 32'(frame_drop_cnt), 32'd0);
    wait_req(20, seen);
    check("both_req_seen", 32'(seen), 32'd1);
    check("both_addr", rd_addr, 32'h1000_0000);
    check("both_wr_base", wr_base_addr, 32'h1004_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
